// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port memory between an instruction-fetch
//             requester and a data (load/store) requester. Ties alternate
//             between the two. Misaligned data requests are rejected without
//             touching memory, and accesses that see no mem_ack within
//             TIMEOUT cycles finish with an error.
//  Ports    : clk, reset (async, active-low)
//             if_req/if_addr            -> fetch request
//             if_valid/if_err/if_rdata  <- fetch completion
//             d_req/d_we/d_addr/d_wdata/d_byte_sel -> data request
//             d_valid/d_err/d_rdata     <- data completion
//             mem_req/mem_we/mem_addr/mem_wdata/mem_byte_sel -> memory
//             mem_ack/mem_rdata         <- memory completion
//             busy                      <- high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [SIZE-1:0] if_addr,
    output logic            if_valid,
    output logic            if_err,
    output logic [SIZE-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [SIZE-1:0] d_addr,
    input  logic [SIZE-1:0] d_wdata,
    input  logic [2:0]      d_byte_sel,
    output logic            d_valid,
    output logic            d_err,
    output logic [SIZE-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    output logic [2:0]      mem_byte_sel,
    input  logic            mem_ack,
    input  logic [SIZE-1:0] mem_rdata,
    output logic            busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_IF_ACC = 2'd1;
    localparam logic [1:0] c_D_ACC  = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] c_WORD_SEL  = 3'b010;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_last_grant_data;
    logic [7:0]      r_wait_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [SIZE-1:0] r_mem_addr;
    logic [SIZE-1:0] r_mem_wdata;
    logic [2:0]      r_mem_byte_sel;
    logic            r_if_valid;
    logic            r_if_err;
    logic [SIZE-1:0] r_if_rdata;
    logic            r_d_valid;
    logic            r_d_err;
    logic [SIZE-1:0] r_d_rdata;

    logic w_misaligned;
    logic w_grant_if;
    logic w_grant_d;
    logic w_timeout;

    // Halfword must be 2-byte aligned, word must be 4-byte aligned.
    assign w_misaligned = ((d_byte_sel[1:0] == 2'b01) && d_addr[0]) ||
                          ((d_byte_sel[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));

    // On a tie the side that did not win last time gets the port.
    assign w_grant_if = if_req && (!d_req || r_last_grant_data);
    assign w_grant_d  = d_req && !w_grant_if;
    assign w_timeout  = (r_wait_cnt >= c_WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_if) begin
                    w_next_state = c_IF_ACC;
                end else if (w_grant_d) begin
                    w_next_state = w_misaligned ? c_RESP : c_D_ACC;
                end
            end
            c_IF_ACC, c_D_ACC: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant_data <= 1'b1;
            r_wait_cnt        <= '0;
            r_mem_req         <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= '0;
            r_mem_byte_sel    <= '0;
            r_if_valid        <= 1'b0;
            r_if_err          <= 1'b0;
            r_if_rdata        <= '0;
            r_d_valid         <= 1'b0;
            r_d_err           <= 1'b0;
            r_d_rdata         <= '0;
        end else begin
            // Completion flags are only ever high for the single RESP cycle.
            r_if_valid <= 1'b0;
            r_if_err   <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_if) begin
                        r_last_grant_data <= 1'b0;
                        r_wait_cnt        <= '0;
                        r_mem_req         <= 1'b1;
                        r_mem_we          <= 1'b0;
                        r_mem_addr        <= if_addr;
                        r_mem_wdata       <= '0;
                        r_mem_byte_sel    <= c_WORD_SEL;
                    end else if (w_grant_d) begin
                        r_last_grant_data <= 1'b1;
                        r_wait_cnt        <= '0;
                        if (w_misaligned) begin
                            r_d_err <= 1'b1;
                        end else begin
                            r_mem_req      <= 1'b1;
                            r_mem_we       <= d_we;
                            r_mem_addr     <= d_addr;
                            r_mem_wdata    <= d_wdata;
                            r_mem_byte_sel <= d_byte_sel;
                        end
                    end
                end
                c_IF_ACC, c_D_ACC: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_state == c_IF_ACC) begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end else begin
                            // A store returns nothing worth keeping.
                            if (!r_mem_we) begin
                                r_d_rdata <= mem_rdata;
                            end
                            r_d_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        if (r_state == c_IF_ACC) begin
                            r_if_err <= 1'b1;
                        end else begin
                            r_d_err <= 1'b1;
                        end
                    end else if (r_wait_cnt != 8'hFF) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_byte_sel = r_mem_byte_sel;
    assign if_valid     = r_if_valid;
    assign if_err       = r_if_err;
    assign if_rdata     = r_if_rdata;
    assign d_valid      = r_d_valid;
    assign d_err        = r_d_err;
    assign d_rdata      = r_d_rdata;
    assign busy         = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter SIZE, default 32, address/data width in bits.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for mem_ack, legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 if_req, if_addr  input  1/SIZE  fetch read request and address; held stable until if_valid or if_err.
REQ-006 if_valid, if_err, if_rdata  output  1/1/SIZE  fetch completion pulse, fetch error pulse, fetch read data.
REQ-007 d_req, d_we, d_addr, d_wdata, d_byte_sel  input  1/1/SIZE/SIZE/3  data-side request; d_byte_sel uses funct3 encoding; all held stable until d_valid or d_err.
REQ-008 d_valid, d_err, d_rdata  output  1/1/SIZE  data completion pulse, data error pulse, data read data.
REQ-009 mem_req, mem_we, mem_addr, mem_wdata, mem_byte_sel  output  1/1/SIZE/SIZE/3  request to the single-port memory.
REQ-010 mem_ack, mem_rdata  input  1/SIZE  one-cycle memory completion and read data, valid in the same cycle.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have four states: IDLE, IF_ACC, D_ACC and RESP.
REQ-013 In IDLE, the arbiter SHALL sample if_req and d_req at the rising edge.
REQ-014 If only one request is present, the arbiter SHALL grant it: IF_ACC for fetch, D_ACC for data.
REQ-015 If both requests are present, the arbiter SHALL grant the requester not recorded in last_grant, then update last_grant to the winner.
REQ-016 A data request SHALL be checked for misalignment in IDLE before it is granted.
REQ-017 Misalignment is: byte_sel[1:0]=01 with addr[0]=1, or byte_sel[1:0]=10 with addr[1:0]!=00.
REQ-018 A misaligned data request SHALL go directly to RESP with d_err set and SHALL NOT assert mem_req.
REQ-019 In IF_ACC and D_ACC, mem_req SHALL be 1 from a registered output, so the first cycle with mem_req high is the cycle after the grant edge.
REQ-020 mem_addr, mem_we, mem_wdata and mem_byte_sel SHALL be registered copies of the granted requester's inputs, and SHALL stay constant while mem_req is 1.
REQ-021 For fetch accesses, mem_we SHALL be 0 and mem_byte_sel SHALL be 3'b010.
REQ-022 On an edge where mem_ack=1 in IF_ACC or D_ACC, the arbiter SHALL: capture mem_rdata into the granted requester's rdata register, clear mem_req, and enter RESP.
REQ-023 Access latency SHALL be 2 cycles plus memory wait: grant edge -> mem_req high -> ack edge -> valid high for one cycle (RESP).
REQ-024 A wait counter SHALL clear on grant and increment each cycle in IF_ACC or D_ACC without mem_ack.
REQ-025 When the wait counter reaches TIMEOUT-1 with no mem_ack, the arbiter SHALL clear mem_req, set the requester's err, and enter RESP; rdata SHALL be unchanged.
REQ-026 mem_ack on the same edge as the timeout SHALL take precedence as a normal completion.
REQ-027 In RESP, exactly one of {if_valid, if_err, d_valid, d_err} SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 Requests SHALL NOT be sampled in RESP.
REQ-029 A requester SHALL drop req by the edge ending its valid/err cycle; a req still high in IDLE is a new request.
REQ-030 if_rdata and d_rdata SHALL hold their last captured value until the next successful access by the same requester.
REQ-031 mem_ack while not in IF_ACC or D_ACC SHALL be ignored.
REQ-032 The wait counter SHALL be 8 bits and SHALL saturate, never wrapping.

Reset
REQ-033 reset low SHALL immediately force:
- state=IDLE, last_grant=DATA (fetch wins the first tie);
- mem_req, mem_we, if_valid, if_err, d_valid, d_err and busy to 0;
- all address/data/byte_sel registers and the wait counter to 0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no valid/err pulse after release.
REQ-035 The first sampling edge after reset release SHALL see IDLE.

Verification
REQ-036 Fetch-only: if_req=1, if_addr=0x100, mem_ack two cycles after mem_req, mem_rdata=0x00000013 -> mem_addr=0x100, mem_we=0, if_rdata=0x13, if_valid one cycle.
REQ-037 Simultaneous requests from reset, held continuously -> grant order fetch, data, fetch, data, with one RESP cycle between each.
REQ-038 Data store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_byte_sel=010, ack after 1 cycle -> mem_we=1 with the matching address/data, d_valid pulse, d_rdata unchanged.
REQ-039 Misaligned access: d_byte_sel=001 with d_addr=0x3, and d_byte_sel=010 with d_addr=0x2 -> mem_req stays 0, d_err pulses, busy high for exactly one cycle.
REQ-040 Timeout: TIMEOUT=4, mem_ack tied 0 -> mem_req high for 4 cycles, then if_err pulse, then IDLE; repeat with mem_ack on the final cycle -> if_valid instead.
REQ-041 Reset asserted during D_ACC -> mem_req drops without a clock edge, and no d_valid or d_err appears after release.
